// File: rtl/nios2_debug_jtag_host_if.sv
// Command/response and virtual-JTAG signal bundle for nios2_debug_jtag_host.
// The master side issues commands and drives tdo; the slave side is the scan engine.
interface nios2_debug_jtag_host_if #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic [DR_WIDTH-1:0] cmd_dr;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_dr;
   logic                busy;
   logic                vji_tck;
   logic                vji_tdi;
   logic                vji_tdo;
   logic [IR_WIDTH-1:0] vji_ir_in;
   logic                vji_rti;
   logic                vji_uir;
   logic                vji_cdr;
   logic                vji_sdr;
   logic                vji_e1dr;

   modport master (
      output cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo,
      input  cmd_ready, rsp_valid, rsp_dr, busy, vji_tck, vji_tdi, vji_ir_in,
             vji_rti, vji_uir, vji_cdr, vji_sdr, vji_e1dr
   );

   modport slave (
      input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo,
      output cmd_ready, rsp_valid, rsp_dr, busy, vji_tck, vji_tdi, vji_ir_in,
             vji_rti, vji_uir, vji_cdr, vji_sdr, vji_e1dr
   );
endinterface

// File: rtl/nios2_debug_jtag_host.sv
// Virtual-JTAG scan engine for the Nios II debug slave: UIR, CDR, DR_WIDTH x SDR, E1DR.
// Response appears (DR_WIDTH+3)*2*TCK_DIV+1 cycles after accept; held until rsp_ready, no new command meanwhile.
module nios2_debug_jtag_host #(
   parameter int TCK_DIV  = 2,
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2
) (
   input logic                    clk,
   input logic                    reset_n,
   nios2_debug_jtag_host_if.slave bus
);
   typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, E1DR} state_e;

   localparam int DIV_W = (2 * TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
   localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

   state_e              state_q, state_d;
   logic [4:0]          strb_q, strb_d;   // {e1dr, sdr, cdr, uir, rti}
   logic [DIV_W-1:0]    div_q;
   logic [BIT_W-1:0]    bit_q;
   logic [DR_WIDTH-1:0] sr_q, cap_q, rsp_dr_q, sr_shift;
   logic [IR_WIDTH-1:0] ir_in_q;
   logic                tck_q, tdi_q, cmd_ready_q, rsp_valid_q, busy_q;
   logic                accept, period_end;

   assign accept     = bus.cmd_valid && cmd_ready_q;
   assign period_end = (state_q != IDLE) && (div_q == DIV_LAST);
   assign sr_shift   = sr_q >> 1;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = UIR;
         UIR:     if (period_end) state_d = CDR;
         CDR:     if (period_end) state_d = SDR;
         SDR:     if (period_end && bit_q == BIT_LAST) state_d = E1DR;
         E1DR:    if (period_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      strb_d = 5'b00001 << state_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         strb_q      <= 5'b00001;
         div_q       <= '0;
         bit_q       <= '0;
         sr_q        <= '0;
         cap_q       <= '0;
         rsp_dr_q    <= '0;
         ir_in_q     <= '0;
         tck_q       <= 1'b0;
         tdi_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         strb_q  <= strb_d;

         // tck: TCK_DIV cycles low then TCK_DIV high, restarted at every period boundary
         if (state_q == IDLE || div_q == DIV_LAST) begin
            div_q <= '0;
            tck_q <= 1'b0;
         end else begin
            div_q <= div_q + 1'b1;
            if (div_q == DIV_RISE) tck_q <= 1'b1;
         end

         if (accept) begin
            sr_q        <= bus.cmd_dr;
            ir_in_q     <= bus.cmd_ir;
            bit_q       <= '0;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
         end

         case (state_q)
            UIR: if (period_end) tdi_q <= sr_q[0];
            SDR: begin
               if (div_q == DIV_RISE) cap_q <= {bus.vji_tdo, cap_q[DR_WIDTH-1:1]};
               if (period_end) begin
                  sr_q  <= sr_shift;
                  bit_q <= bit_q + 1'b1;
                  tdi_q <= (bit_q == BIT_LAST) ? 1'b0 : sr_shift[0];
               end
            end
            E1DR: if (period_end) begin
               rsp_dr_q    <= cap_q;
               rsp_valid_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: ;
         endcase

         if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
         end
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_dr    = rsp_dr_q;
   assign bus.busy      = busy_q;
   assign bus.vji_tck   = tck_q;
   assign bus.vji_tdi   = tdi_q;
   assign bus.vji_ir_in = ir_in_q;
   assign bus.vji_rti   = strb_q[0];
   assign bus.vji_uir   = strb_q[1];
   assign bus.vji_cdr   = strb_q[2];
   assign bus.vji_sdr   = strb_q[3];
   assign bus.vji_e1dr  = strb_q[4];
endmodule

// File: tb/tb_nios2_debug_jtag_host.sv
// Bench for nios2_debug_jtag_host: TCK_DIV=2 and TCK_DIV=1 instances, waveform and
// response checked each cycle against a period/phase model of the scan sequence.
module tb_nios2_debug_jtag_host;
   localparam int DW = 38;

   logic          clk = 1'b0;
   logic          rst_n, cmd_valid, rsp_ready, tdo, sel;
   logic [1:0]    cmd_ir;
   logic [DW-1:0] cmd_dr;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   nios2_debug_jtag_host_if #(.DR_WIDTH(DW), .IR_WIDTH(2)) b0 ();
   nios2_debug_jtag_host_if #(.DR_WIDTH(DW), .IR_WIDTH(2)) b1 ();

   assign b0.cmd_valid = cmd_valid & ~sel;
   assign b0.cmd_ir    = cmd_ir;
   assign b0.cmd_dr    = cmd_dr;
   assign b0.rsp_ready = rsp_ready & ~sel;
   assign b0.vji_tdo   = tdo;
   assign b1.cmd_valid = cmd_valid & sel;
   assign b1.cmd_ir    = cmd_ir;
   assign b1.cmd_dr    = cmd_dr;
   assign b1.rsp_ready = rsp_ready & sel;
   assign b1.vji_tdo   = tdo;

   nios2_debug_jtag_host #(.TCK_DIV(2), .DR_WIDTH(DW), .IR_WIDTH(2)) dut0 (
      .clk(clk), .reset_n(rst_n), .bus(b0));
   nios2_debug_jtag_host #(.TCK_DIV(1), .DR_WIDTH(DW), .IR_WIDTH(2)) dut1 (
      .clk(clk), .reset_n(rst_n), .bus(b1));

   logic          o_ready, o_rvalid, o_busy, o_tck, o_tdi;
   logic [DW-1:0] o_rdr;
   logic [1:0]    o_ir;
   logic [4:0]    o_strb;
   assign o_ready  = sel ? b1.cmd_ready : b0.cmd_ready;
   assign o_rvalid = sel ? b1.rsp_valid : b0.rsp_valid;
   assign o_busy   = sel ? b1.busy      : b0.busy;
   assign o_tck    = sel ? b1.vji_tck   : b0.vji_tck;
   assign o_tdi    = sel ? b1.vji_tdi   : b0.vji_tdi;
   assign o_rdr    = sel ? b1.rsp_dr    : b0.rsp_dr;
   assign o_ir     = sel ? b1.vji_ir_in : b0.vji_ir_in;
   assign o_strb   = sel ? {b1.vji_e1dr, b1.vji_sdr, b1.vji_cdr, b1.vji_uir, b1.vji_rti}
                         : {b0.vji_e1dr, b0.vji_sdr, b0.vji_cdr, b0.vji_uir, b0.vji_rti};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_dr();
      return DW'({$urandom(), $urandom()});
   endfunction

   // Scan one command; expected waveform follows from period p and phase ph since accept.
   task automatic run_scan(input logic [1:0] ir, input logic [DW-1:0] dr, input bit loop,
                           input logic [DW-1:0] pat, input int rst_at, output logic [DW-1:0] exp_dr);
      int t, lat, p, ph, errs, first_bad;
      logic [4:0] e_strb;
      logic       e_tdi;
      t = sel ? 1 : 2;
      lat = 1 + (DW + 3) * 2 * t;
      exp_dr = loop ? dr : pat;
      errs = 0;
      first_bad = 0;
      check("ready_idle", o_ready, 1);
      cmd_valid = 1'b1;
      cmd_ir = ir;
      cmd_dr = dr;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         p  = (c - 1) / (2 * t);
         ph = (c - 1) % (2 * t);
         e_strb = (p == 0) ? 5'b00010 : (p == 1) ? 5'b00100 : (p <= DW + 1) ? 5'b01000 :
                  (p == DW + 2) ? 5'b10000 : 5'b00001;
         e_tdi = (p == 1) ? dr[0] : (p >= 2 && p <= DW + 1) ? dr[p-2] : 1'b0;
         if (o_strb !== e_strb || o_tck !== (ph >= t) || o_tdi !== e_tdi || o_ir !== ir ||
             o_busy !== (c < lat) || o_rvalid !== (c == lat) || o_ready !== 1'b0) begin
            if (errs == 0) first_bad = c;
            errs++;
         end
         if (c == rst_at) begin
            tdo = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("rst_strobes", o_strb, 5'b00001);
            check("rst_tck", o_tck, 0);
            check("rst_busy", o_busy, 0);
            check("rst_rvalid", o_rvalid, 0);
            check("rst_ready", o_ready, 1);
            check($sformatf("wave_pre_rst(first bad cycle %0d)", first_bad), errs, 0);
            errs = 0;
            for (int w = 0; w < lat; w++) begin
               @(negedge clk);
               if (o_rvalid !== 1'b0 || o_strb !== 5'b00001) errs++;
            end
            check("no_rsp_after_rst", errs, 0);
            return;
         end
         tdo = loop ? o_tdi : ((p >= 2 && p <= DW + 1) ? pat[p-2] : 1'b0);
      end
      tdo = 1'b0;
      check($sformatf("wave(first bad cycle %0d)", first_bad), errs, 0);
      check("rsp_dr", o_rdr, exp_dr);
   endtask

   task automatic respond(input int hold, input bit keep, input logic [DW-1:0] exp_dr);
      int errs;
      errs = 0;
      rsp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = keep;
         cmd_dr = rnd_dr();
         @(negedge clk);
         if (o_rvalid !== 1'b1 || o_rdr !== exp_dr || o_ready !== 1'b0 ||
             o_strb !== 5'b00001 || o_busy !== 1'b0 || o_tck !== 1'b0) errs++;
      end
      if (hold > 0) check("hold_stable", errs, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_cleared", o_rvalid, 0);
      check("ready_after_rsp", o_ready, 1);
   endtask

   initial begin
      logic [DW-1:0] d, e, pat;
      sel = 1'b0;
      rst_n = 1'b0;
      cmd_valid = 1'b1;
      cmd_ir = 2'b11;
      cmd_dr = '1;
      rsp_ready = 1'b0;
      tdo = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_ready", o_ready, 1);
         check("reset_strobes", o_strb, 5'b00001);
         check("reset_tck", o_tck, 0);
         check("reset_rvalid", o_rvalid, 0);
         check("reset_busy", o_busy, 0);
         check("reset_rdr", o_rdr, 0);
         check("reset_ir", o_ir, 0);
         check("reset_tdi", o_tdi, 0);
      end
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("no_accept_strobes", o_strb, 5'b00001);
      check("no_accept_busy", o_busy, 0);

      d = 38'h2A_5A5A_A5A5;
      run_scan(2'b01, d, 1'b1, '0, 0, e);
      respond(0, 1'b0, e);

      pat = 38'h1;
      run_scan(2'b10, rnd_dr(), 1'b0, pat, 0, e);
      respond(0, 1'b0, e);
      pat = 38'h20_0000_0000;
      run_scan(2'b11, rnd_dr(), 1'b0, pat, 0, e);
      respond(0, 1'b0, e);

      for (int i = 0; i < 4; i++) begin
         run_scan(2'($urandom_range(0, 3)), rnd_dr(), 1'b1, '0, 0, e);
         respond(0, 1'b0, e);
      end
      for (int i = 0; i < 2; i++) begin
         run_scan(2'($urandom_range(0, 3)), rnd_dr(), 1'b0, rnd_dr(), 0, e);
         respond(0, 1'b0, e);
      end

      run_scan(2'($urandom_range(0, 3)), rnd_dr(), 1'b1, '0, 0, e);
      respond(10, 1'b1, e);
      run_scan(2'($urandom_range(0, 3)), rnd_dr(), 1'b1, '0, 0, e);
      respond(0, 1'b0, e);

      // reset lands inside SDR period 10 (scan period 12)
      run_scan(2'b01, rnd_dr(), 1'b1, '0, 1 + 12 * 4 + 1, e);
      run_scan(2'b10, rnd_dr(), 1'b1, '0, 0, e);
      respond(0, 1'b0, e);

      sel = 1'b1;
      @(negedge clk);
      d = '1;
      run_scan(2'b01, d, 1'b1, '0, 0, e);
      respond(0, 1'b0, e);
      run_scan(2'($urandom_range(0, 3)), rnd_dr(), 1'b1, '0, 0, e);
      respond(0, 1'b0, e);
      run_scan(2'($urandom_range(0, 3)), rnd_dr(), 1'b0, rnd_dr(), 0, e);
      respond(0, 1'b0, e);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
